// File: rtl/parallel_serializer_pkg.sv
// rtl/parallel_serializer_pkg.sv - shared types and helpers for the parallel serializer
//
// Purpose : shift-engine state encoding and the output-bit selector used by
//           the shift core.
// Ports   : none (package).
package par_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Bit presented on the serial line: the shifter's top bit when sending
  // MSB first, its bottom bit otherwise.
  function automatic logic out_bit(input logic msb_bit,
                                   input logic lsb_bit,
                                   input bit   msb_first);
    return msb_first ? msb_bit : lsb_bit;
  endfunction

endpackage

// File: rtl/parallel_serializer_if.sv
// rtl/parallel_serializer_if.sv - word-in / bit-out handshake bundle
//
// Purpose : groups the parallel input handshake and the serial output
//           signals of the serializer.
// Signals : din_parallel, din_valid (producer -> serializer)
//           din_ready (serializer -> producer)
//           dout_serial, dout_valid, dout_last (serializer -> link)
// Modports: master = producer/link side, slave = serializer side.
interface par_ser_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] din_parallel;
  logic              din_valid;
  logic              din_ready;
  logic              dout_serial;
  logic              dout_valid;
  logic              dout_last;

  modport master (
    output din_parallel,
    output din_valid,
    input  din_ready,
    input  dout_serial,
    input  dout_valid,
    input  dout_last
  );

  modport slave (
    input  din_parallel,
    input  din_valid,
    output din_ready,
    output dout_serial,
    output dout_valid,
    output dout_last
  );

endinterface

// File: rtl/parallel_serializer_shift_core.sv
// rtl/parallel_serializer_shift_core.sv - shifter, bit counter and shift FSM
//
// Purpose : shifts a loaded word out one bit per clock, reloading from the
//           holding register on the final bit so words stream gaplessly.
// Ports   : clk, rstn (async active-low), clr (sync flush)
//           hold_full, hold_data : holding register contents from the top
//           load                 : this edge takes hold_data into the shifter
//           active               : shifter is sending (state == SHIFT)
//           dout_serial, dout_valid, dout_last : serial output
module ser_shift_core
  import par_ser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              hold_full,
  input  logic [DATA_W-1:0] hold_data,
  output logic              load,
  output logic              active,
  output logic              dout_serial,
  output logic              dout_valid,
  output logic              dout_last
);

  localparam int               CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  ser_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shifter;
  logic [DATA_W-1:0] shifted;
  logic              at_last;

  assign at_last = (state == SHIFT) && (cnt == LAST);

  // A load happens either from IDLE or on the final bit of the current word;
  // clr wins so a flush never pulls the held word into the shifter.
  assign load = hold_full && !clr && ((state == IDLE) || (cnt == LAST));

  always_comb begin
    shifted = shifter;
    if (MSB_FIRST != 0) begin
      shifted = {shifter[DATA_W-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shifter[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      shifter <= '0;
    end else if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      shifter <= '0;
    end else if (load) begin
      shifter <= hold_data;
      cnt     <= '0;
      state   <= SHIFT;
    end else if (state == SHIFT) begin
      if (cnt == LAST) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        shifter <= shifted;
        cnt     <= cnt + 1'b1;
      end
    end
  end

  assign active      = (state == SHIFT);
  assign dout_valid  = active;
  assign dout_last   = at_last;
  assign dout_serial = active &
                       out_bit(shifter[DATA_W-1], shifter[0], MSB_FIRST != 0);

endmodule

// File: rtl/parallel_serializer.sv
// rtl/parallel_serializer.sv - parallel-to-serial converter with holding register
//
// Purpose : accepts DATA_W-bit words on a valid/ready handshake into a
//           one-word holding register and streams them out bit-serially,
//           back-to-back with no idle bit between words.
// Ports   : clk, rstn (async active-low), clr (sync flush of held and
//           in-flight words)
//           bus  : par_ser_if slave (din_parallel/din_valid/din_ready,
//                  dout_serial/dout_valid/dout_last)
//           busy : a word is shifting or waiting in the holding register
module parallel_serializer
  import par_ser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    clr,
  par_ser_if.slave bus,
  output logic    busy
);

  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic              accept;
  logic              load;
  logic              active;

  // Ready is purely the inverse of the registered hold_full flag, so an
  // accept and a reload can never fall on the same edge.
  assign bus.din_ready = ~hold_full;
  assign accept        = bus.din_valid && !hold_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (clr) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= bus.din_parallel;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  ser_shift_core #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .hold_full  (hold_full),
    .hold_data  (hold),
    .load       (load),
    .active     (active),
    .dout_serial(bus.dout_serial),
    .dout_valid (bus.dout_valid),
    .dout_last  (bus.dout_last)
  );

  assign busy = active | hold_full;

endmodule

// File: tb/tb_parallel_serializer.sv
// tb/tb_parallel_serializer.sv - self-checking bench for parallel_serializer
module tb_parallel_serializer;

  logic clk;
  logic rstn;

  logic [7:0] d_in [3];
  logic       v_in [3];
  logic       c_in [3];

  logic o_ser [3];
  logic o_val [3];
  logic o_last[3];
  logic o_rdy [3];
  logic o_busy[3];

  par_ser_if #(.DATA_W(8)) bus0 ();
  par_ser_if #(.DATA_W(8)) bus1 ();
  par_ser_if #(.DATA_W(2)) bus2 ();

  assign bus0.din_parallel = d_in[0];
  assign bus0.din_valid    = v_in[0];
  assign bus1.din_parallel = d_in[1];
  assign bus1.din_valid    = v_in[1];
  assign bus2.din_parallel = d_in[2][1:0];
  assign bus2.din_valid    = v_in[2];

  assign o_ser[0] = bus0.dout_serial; assign o_val[0] = bus0.dout_valid;
  assign o_last[0] = bus0.dout_last;  assign o_rdy[0] = bus0.din_ready;
  assign o_ser[1] = bus1.dout_serial; assign o_val[1] = bus1.dout_valid;
  assign o_last[1] = bus1.dout_last;  assign o_rdy[1] = bus1.din_ready;
  assign o_ser[2] = bus2.dout_serial; assign o_val[2] = bus2.dout_valid;
  assign o_last[2] = bus2.dout_last;  assign o_rdy[2] = bus2.din_ready;

  parallel_serializer #(.DATA_W(8), .MSB_FIRST(1)) u_msb8 (
    .clk(clk), .rstn(rstn), .clr(c_in[0]), .bus(bus0), .busy(o_busy[0]));
  parallel_serializer #(.DATA_W(8), .MSB_FIRST(0)) u_lsb8 (
    .clk(clk), .rstn(rstn), .clr(c_in[1]), .bus(bus1), .busy(o_busy[1]));
  parallel_serializer #(.DATA_W(2), .MSB_FIRST(1)) u_msb2 (
    .clk(clk), .rstn(rstn), .clr(c_in[2]), .bus(bus2), .busy(o_busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one word waiting, one word in flight described by its
  // value and how many of its bits are still to be shown on the line.
  int         wid  [3] = '{8, 8, 2};
  bit         msbf [3] = '{1'b1, 1'b0, 1'b1};
  bit         held [3];
  logic [7:0] hw   [3];
  logic [7:0] fw   [3];
  int         rem  [3];
  bit         acc  [3];

  logic [31:0] cap   [3];
  int          capn  [3];
  int          lastn [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      held[k] = 1'b0;
      rem[k]  = 0;
    end
  endtask

  task automatic model_edge(input int k);
    bit acc_now;
    if (!rstn || c_in[k]) begin
      held[k] = 1'b0;
      rem[k]  = 0;
      return;
    end
    acc_now = v_in[k] && !held[k];
    if (rem[k] > 0) rem[k]--;
    if (rem[k] == 0 && held[k]) begin
      fw[k]   = hw[k];
      rem[k]  = wid[k];
      held[k] = 1'b0;
    end
    if (acc_now) begin
      held[k] = 1'b1;
      hw[k]   = d_in[k] & 8'((1 << wid[k]) - 1);
      acc[k]  = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [4:0] e;
    logic       eb;
    int         idx;
    for (int k = 0; k < 3; k++) begin
      eb = 1'b0;
      if (rem[k] > 0) begin
        idx = wid[k] - rem[k];
        eb  = msbf[k] ? fw[k][wid[k] - 1 - idx] : fw[k][idx];
      end
      e = {rem[k] > 0, eb, rem[k] == 1, !held[k], (rem[k] > 0) || held[k]};
      chk($sformatf("out%0d", k),
          {27'd0, o_val[k], o_ser[k], o_last[k], o_rdy[k], o_busy[k]},
          {27'd0, e});
    end
  endtask

  task automatic clear_caps();
    for (int k = 0; k < 3; k++) begin
      cap[k] = '0; capn[k] = 0; lastn[k] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      acc[k] = 1'b0;
      model_edge(k);
    end
    @(negedge clk);
    check_all();
    for (int k = 0; k < 3; k++) begin
      if (o_val[k]) begin
        cap[k] = {cap[k][30:0], o_ser[k]};
        capn[k]++;
        if (o_last[k]) lastn[k]++;
      end
    end
  endtask

  task automatic send(input int k, input logic [7:0] w);
    int n;
    v_in[k] = 1'b1;
    d_in[k] = w;
    n = 0;
    acc[k] = 1'b0;
    while (!acc[k] && n < 40) begin
      step();
      n++;
    end
    if (!acc[k]) chk($sformatf("accept_timeout%0d", k), 32'd0, 32'd1);
    v_in[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d_in[k] = '0; v_in[k] = 1'b0; c_in[k] = 1'b0;
    end
    model_reset();
    clear_caps();
    repeat (2) @(negedge clk);
    check_all();
    rstn = 1'b1;
    idle(2);

    // back-to-back MSB-first words
    clear_caps();
    send(0, 8'hA5);
    send(0, 8'h3C);
    idle(20);
    chk("a5_3c_bits", cap[0], 32'h0000_A53C);
    chk("a5_3c_len", capn[0], 32'd16);
    chk("a5_3c_last", lastn[0], 32'd2);

    // LSB-first single word
    clear_caps();
    send(1, 8'h01);
    idle(10);
    chk("lsb_01_bits", cap[1], 32'h0000_0080);
    chk("lsb_01_len", capn[1], 32'd8);

    // two-bit words streamed
    clear_caps();
    send(2, 8'h02);
    send(2, 8'h01);
    idle(6);
    chk("w2_bits", cap[2], 32'h0000_0009);
    chk("w2_last", lastn[2], 32'd2);

    // flush after the third bit with a word held
    send(0, 8'hFF);
    send(0, 8'h55);
    n = 0;
    while (rem[0] != 5 && n < 20) begin
      step();
      n++;
    end
    if (rem[0] != 5) chk("clr_wait_timeout", 32'd0, 32'd1);
    c_in[0] = 1'b1;
    step();
    c_in[0] = 1'b0;
    chk("clr_valid", {31'd0, o_val[0]}, 32'd0);
    chk("clr_busy", {31'd0, o_busy[0]}, 32'd0);
    chk("clr_ready", {31'd0, o_rdy[0]}, 32'd1);
    clear_caps();
    send(0, 8'h81);
    idle(12);
    chk("post_clr_bits", cap[0], 32'h0000_0081);
    chk("post_clr_len", capn[0], 32'd8);

    // asynchronous reset mid-word
    send(0, 8'hC3);
    idle(3);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_valid", {31'd0, o_val[0]}, 32'd0);
    chk("arst_ready", {31'd0, o_rdy[0]}, 32'd1);
    idle(2);
    rstn = 1'b1;
    clear_caps();
    send(0, 8'hC3);
    idle(12);
    chk("post_rst_bits", cap[0], 32'h0000_00C3);
    chk("post_rst_len", capn[0], 32'd8);

    // randomized traffic on all three instances
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 3; k++) begin
        v_in[k] = ($urandom_range(0, 3) != 0);
        d_in[k] = 8'($urandom);
        c_in[k] = ($urandom_range(0, 49) == 0);
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      v_in[k] = 1'b0; c_in[k] = 1'b0;
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parallel_serializer.md
# parallel_serializer

Parametrised parallel-to-serial converter with a valid/ready input handshake and a one-word holding register. A full-width word is accepted while the current word is still shifting out, so back-to-back words stream with no idle bit between them. Bit order is selectable. The block sits between a word-oriented producer and a single-bit serial link, and it replaces fixed 8-bit, handshake-free serialisation.

## Interface
- DATA_W, 8, word width in bits; legal range is 2 and above.
- MSB_FIRST, 1, 1 = bit DATA_W-1 goes out first; 0 = bit 0 goes out first.
- clk  in  1  rising-edge clock.
- rstn  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous flush; drops the held word and the word in flight.
- din_parallel  in  DATA_W  input word.
- din_valid  in  1  din_parallel is valid.
- din_ready  out  1  holding register is empty; the block can accept a word.
- dout_serial  out  1  serial data bit.
- dout_valid  out  1  dout_serial carries a valid bit.
- dout_last  out  1  dout_serial is the final bit of the current word.
- busy  out  1  a word is being shifted or is waiting in the holding register.

## Operation
- Accept: a word is accepted on any rising edge where din_valid && din_ready. It is written into the holding register (hold), and hold_full is set.
- din_ready is the inverse of hold_full. It comes from a register only, with no combinational path from din_valid.
- Shift engine states:
  - IDLE → SHIFT on an edge where hold_full = 1. That edge loads the shifter from hold, clears hold_full, and sets cnt = 0.
  - SHIFT: each edge advances one bit and increments cnt.
  - At cnt = DATA_W-1:
    - if hold_full, reload the shifter from hold, clear hold_full, set cnt = 0, stay in SHIFT (gapless);
    - otherwise go to IDLE.
- Outputs:
  - dout_serial = shifter[DATA_W-1] when MSB_FIRST = 1, else shifter[0]. The shifter moves left or right to match.
  - dout_valid = (state == SHIFT).
  - dout_last = SHIFT && cnt == DATA_W-1.
  - dout_serial is forced to 0 when dout_valid = 0.
- busy = (state == SHIFT) || hold_full.
- cnt width is $clog2(DATA_W). cnt never exceeds DATA_W-1; there is no wrap beyond that.
- Simultaneous events:
  - An accept and a shifter reload cannot occur on the same edge, because din_ready is 0 whenever hold_full = 1. After a reload, din_ready rises in the next cycle.
  - clr has priority over everything. On the clr edge: hold_full → 0, state → IDLE, cnt → 0. A word presented with din_valid && din_ready on that edge is dropped.
  - din_valid that drops mid-word has no effect on the word in flight. No pre-accept value is required to be held stable.
- Reset (asynchronous, any time, including mid-word):
  - state = IDLE, cnt = 0, hold_full = 0, shifter = 0.
  - Resulting outputs: dout_serial = 0, dout_valid = 0, dout_last = 0, busy = 0, din_ready = 1.
  - The in-flight word is lost.

## Timing
- Latency: a word accepted at edge N loads at edge N+1. Its first bit is valid in the cycle after edge N+1, and its last bit in the cycle after edge N+DATA_W.
- Throughput: one word per DATA_W cycles when the producer keeps hold full. dout_valid stays continuously high across word boundaries.
- Flush: after a clr edge, dout_valid = 0 in the following cycle and din_ready = 1.
- All outputs are registered or are decoded from registers only. The block has no input-to-output combinational path.

## Structure
- Shared package par_ser_pkg:
  - state enum ser_state_e {IDLE, SHIFT};
  - a function that returns the output bit of a word, selected by MSB_FIRST.
- Sub-module ser_shift_core: the shifter, cnt and state FSM, with load/last handshake to the top level.
- The top level contains the holding register, the input handshake and the clr/busy logic.

## Test plan
All scenarios use DATA_W = 8 unless noted.
- Single word, MSB_FIRST = 1: 0xA5 accepted at edge 0 → dout_valid high in cycles 2–9 with bits 1,0,1,0,0,1,0,1; dout_last only in cycle 9; busy low from cycle 10.
- Back-to-back: 0xA5 then 0x3C, din_valid held high → 16 contiguous valid bits ending 0,0,1,1,1,1,0,0; dout_last in cycles 9 and 17; din_ready low while hold is full.
- LSB-first, MSB_FIRST = 0: 0x01 → bits 1,0,0,0,0,0,0,0.
- clr after the third bit of 0xFF, with 0x55 held:
  - next cycle: dout_valid = 0, busy = 0, din_ready = 1;
  - a subsequent 0x81 serialises fully as 1,0,0,0,0,0,0,1.
- Async reset asserted mid-word between clock edges → all outputs at reset values immediately; after release, 0xC3 serialises correctly.
- DATA_W = 2: words 0b10 and 0b01 streamed → bits 1,0,0,1 contiguous; dout_last on the 2nd and 4th bits.
